conv_bin_layer: RTL and testbench

- Parametrised binary 3x3 convolution layer for the MNIST inference pipeline. Successor to the fixed 28x28, 8-channel first conv stage.
- Accepts a 1-bit pixel stream with a valid/start-of-frame qualifier and builds 3x3 windows with an internal line buffer.
- Per output channel, computes an XNOR-popcount against a per-channel weight mask and compares it with a per-channel threshold.
- Emits one bit per channel per valid window, with frame-end signalling, for the pooling stage downstream.

---
 rtl/conv_bin_pkg.sv | 38 +++
 rtl/conv_bin_linebuf.sv | 87 ++++++++
 rtl/conv_bin_layer.sv | 82 ++++++++
 tb/tb_conv_bin_layer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_bin_pkg.sv
// Shared constants and helpers for the binary 3x3 convolution layer.
package conv_bin_pkg;

    // Window bit positions: row-major, row 0 and column 0 are the oldest pixels.
    localparam int unsigned WIN_TL   = 0;
    localparam int unsigned WIN_TC   = 1;
    localparam int unsigned WIN_TR   = 2;
    localparam int unsigned WIN_ML   = 3;
    localparam int unsigned WIN_MC   = 4;
    localparam int unsigned WIN_MR   = 5;
    localparam int unsigned WIN_BL   = 6;
    localparam int unsigned WIN_BC   = 7;
    localparam int unsigned WIN_BR   = 8;
    localparam int unsigned WIN_SIZE = 9;

    // Widest channel count the slicing helpers accept.
    localparam int unsigned CH_MAX = 32;

    function automatic logic [3:0] popcount9(input logic [WIN_SIZE-1:0] bits);
        logic [3:0] cnt;
        cnt = '0;
        for (int k = 0; k < WIN_SIZE; k++) begin
            cnt = cnt + {3'b000, bits[k]};
        end
        return cnt;
    endfunction

    function automatic logic [WIN_SIZE-1:0] weight_slice(input logic [CH_MAX*9-1:0] weights,
                                                         input int unsigned ch);
        return weights[ch*9 +: 9];
    endfunction

    function automatic logic [3:0] thresh_slice(input logic [CH_MAX*4-1:0] thresh,
                                                input int unsigned ch);
        return thresh[ch*4 +: 4];
    endfunction

endpackage

// File: rtl/conv_bin_linebuf.sv
// Line buffer and 3x3 window builder for a 1-bit raster pixel stream.
module conv_bin_linebuf
    import conv_bin_pkg::*;
#(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic                i_sof,
    input  logic                i_pixel,
    output logic [WIN_SIZE-1:0] o_window,
    output logic                o_win_valid,
    output logic                o_win_last
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_WIN  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(2);

    logic [COL_W-1:0]    r_col, w_col_cur, w_col_nxt;
    logic [ROW_W-1:0]    r_row, w_row_cur, w_row_nxt;
    logic [IMG_W-1:0]    r_line1, r_line2;
    logic [WIN_SIZE-1:0] r_window, w_window_d;
    logic                r_win_valid, r_win_last;
    logic                w_tap1, w_tap2, w_win_ok, w_at_last;

    // Position of the pixel on the inputs, next position, and the shifted window.
    always_comb begin
        w_col_cur = i_sof ? '0 : r_col;
        w_row_cur = i_sof ? '0 : r_row;
        w_col_nxt = w_col_cur + COL_W'(1);
        w_row_nxt = w_row_cur;
        if (w_col_cur == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row_cur == ROW_LAST) ? '0 : w_row_cur + ROW_W'(1);
        end
        // Taps are the same column one and two rows back.
        w_tap1    = r_line1[IMG_W-1];
        w_tap2    = r_line2[IMG_W-1];
        w_win_ok  = (w_row_cur >= ROW_WIN) && (w_col_cur >= COL_WIN);
        w_at_last = (w_row_cur == ROW_LAST) && (w_col_cur == COL_LAST);

        w_window_d         = r_window;
        w_window_d[WIN_TL] = r_window[WIN_TC];
        w_window_d[WIN_TC] = r_window[WIN_TR];
        w_window_d[WIN_TR] = w_tap2;
        w_window_d[WIN_ML] = r_window[WIN_MC];
        w_window_d[WIN_MC] = r_window[WIN_MR];
        w_window_d[WIN_MR] = w_tap1;
        w_window_d[WIN_BL] = r_window[WIN_BC];
        w_window_d[WIN_BC] = r_window[WIN_BR];
        w_window_d[WIN_BR] = i_pixel;
    end

    // Counters, delay lines and window advance only on an accepted pixel.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_line1     <= '0;
            r_line2     <= '0;
            r_window    <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else begin
            r_win_valid <= i_valid && w_win_ok;
            r_win_last  <= i_valid && w_win_ok && w_at_last;
            if (i_valid) begin
                r_col    <= w_col_nxt;
                r_row    <= w_row_nxt;
                r_line1  <= {r_line1[IMG_W-2:0], i_pixel};
                r_line2  <= {r_line2[IMG_W-2:0], w_tap1};
                r_window <= w_window_d;
            end
        end
    end

    assign o_window    = r_window;
    assign o_win_valid = r_win_valid;
    assign o_win_last  = r_win_last;

endmodule

// File: rtl/conv_bin_layer.sv
// Binary 3x3 convolution: XNOR-popcount per channel against a threshold.
module conv_bin_layer
    import conv_bin_pkg::*;
#(
    parameter int unsigned         IMG_W   = 28,
    parameter int unsigned         IMG_H   = 28,
    parameter int unsigned         CH_OUT  = 8,
    parameter logic [CH_OUT*9-1:0] WEIGHTS = '0,
    parameter logic [CH_OUT*4-1:0] THRESH  = {CH_OUT{4'd5}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              sof_in,
    input  logic              pixel_in,
    output logic [CH_OUT-1:0] conv_out,
    output logic              valid_out,
    output logic              eof_out
);

    if (IMG_W < 3) begin : g_bad_w
        $fatal(1, "conv_bin_layer: IMG_W must be >= 3");
    end
    if (IMG_H < 3) begin : g_bad_h
        $fatal(1, "conv_bin_layer: IMG_H must be >= 3");
    end
    if (CH_OUT < 1 || CH_OUT > CH_MAX) begin : g_bad_ch
        $fatal(1, "conv_bin_layer: CH_OUT must be 1..32");
    end

    localparam logic [CH_MAX*9-1:0] WEIGHTS_EXT = (CH_MAX*9)'(WEIGHTS);
    localparam logic [CH_MAX*4-1:0] THRESH_EXT  = (CH_MAX*4)'(THRESH);

    logic [WIN_SIZE-1:0] w_window;
    logic                w_win_valid, w_win_last;
    logic [CH_OUT-1:0]   w_conv_d;
    logic [CH_OUT-1:0]   r_conv;
    logic                r_valid, r_eof;

    conv_bin_linebuf #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_linebuf (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid_in),
        .i_sof       (sof_in),
        .i_pixel     (pixel_in),
        .o_window    (w_window),
        .o_win_valid (w_win_valid),
        .o_win_last  (w_win_last)
    );

    for (genvar ch = 0; ch < CH_OUT; ch++) begin : g_ch
        if (THRESH[ch*4 +: 4] > 4'd9) begin : g_bad_thresh
            $fatal(1, "conv_bin_layer: THRESH field exceeds 9");
        end
        logic [3:0] w_match;
        assign w_match     = popcount9(~(w_window ^ weight_slice(WEIGHTS_EXT, ch)));
        assign w_conv_d[ch] = (w_match >= thresh_slice(THRESH_EXT, ch));
    end

    // Output registers; conv_out only updates on a valid window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conv  <= '0;
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_valid <= w_win_valid;
            r_eof   <= w_win_valid && w_win_last;
            if (w_win_valid) begin
                r_conv <= w_conv_d;
            end
        end
    end

    assign conv_out  = r_conv;
    assign valid_out = r_valid;
    assign eof_out   = r_eof;

endmodule

// File: tb/tb_conv_bin_layer.sv
// Scoreboard bench: a frame-array model predicts every window output and its cycle.
module tb_conv_bin_layer;

    // Channel 7 .. channel 0.
    localparam logic [71:0] WA = {9'h13C, 9'h0F0, 9'h000, 9'h1FF, 9'h155, 9'h0AA, 9'h000, 9'h1FF};
    localparam logic [31:0] TA = {4'd4, 4'd7, 4'd5, 4'd9, 4'd0, 4'd3, 4'd9, 4'd5};
    localparam logic [17:0] WB = {9'h0B3, 9'h1FF};
    localparam logic [7:0]  TB = {4'd0, 4'd9};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic va = 1'b0, sa = 1'b0, pa = 1'b0;
    logic vb = 1'b0, sb = 1'b0, pb = 1'b0;
    logic [7:0] conv_a;
    logic       valid_a, eof_a;
    logic [1:0] conv_b;
    logic       valid_b, eof_b;

    conv_bin_layer #(
        .IMG_W   (28),
        .IMG_H   (28),
        .CH_OUT  (8),
        .WEIGHTS (WA),
        .THRESH  (TA)
    ) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (va),
        .sof_in    (sa),
        .pixel_in  (pa),
        .conv_out  (conv_a),
        .valid_out (valid_a),
        .eof_out   (eof_a)
    );

    conv_bin_layer #(
        .IMG_W   (5),
        .IMG_H   (4),
        .CH_OUT  (2),
        .WEIGHTS (WB),
        .THRESH  (TB)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (vb),
        .sof_in    (sb),
        .pixel_in  (pb),
        .conv_out  (conv_b),
        .valid_out (valid_b),
        .eof_out   (eof_b)
    );

    typedef struct {
        int         cyc;
        logic [7:0] conv;
        logic       eof;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int img_w[2] = '{28, 5};
    int img_h[2] = '{28, 4};
    int nch[2]   = '{8, 2};
    logic [8:0] wt[2][8];
    logic [3:0] th[2][8];
    logic mpix[2][28][28];
    int mr[2], mc[2];
    logic [7:0] last_conv[2];
    int dv[2], de[2];
    bit mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Records the pixel at its frame position and predicts any window it completes.
    task automatic model_px(input int d, input logic p, input logic s);
        int   r, c, m;
        exp_t x;
        r = s ? 0 : mr[d];
        c = s ? 0 : mc[d];
        mpix[d][r][c] = p;
        if (r >= 2 && c >= 2) begin
            x.conv = '0;
            for (int ch = 0; ch < nch[d]; ch++) begin
                m = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        if (mpix[d][r-2+i][c-2+j] == wt[d][ch][3*i+j]) m++;
                    end
                end
                x.conv[ch] = (m >= int'(th[d][ch]));
            end
            x.cyc = cyc + 2;
            x.eof = (r == img_h[d] - 1) && (c == img_w[d] - 1);
            if (d == 0) qa.push_back(x);
            else qb.push_back(x);
        end
        c++;
        if (c == img_w[d]) begin
            c = 0;
            r = (r == img_h[d] - 1) ? 0 : r + 1;
        end
        mr[d] = r;
        mc[d] = c;
    endtask

    task automatic drive_px(input int d, input logic p, input logic s);
        if (d == 0) begin va = 1'b1; sa = s; pa = p; end
        else begin vb = 1'b1; sb = s; pb = p; end
        model_px(d, p, s);
        @(negedge clk);
        va = 1'b0; sa = 1'b0; vb = 1'b0; sb = 1'b0;
    endtask

    function automatic logic gen_px(input int kind, input int i, input int w);
        int col;
        col = i % w;
        case (kind)
            0:       return 1'b0;
            1:       return col[0];
            2:       return 1'($urandom_range(1));
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_frame(input int d, input int kind, input int n, input bit sof_first,
                             input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(1) == 1) @(negedge clk);
            drive_px(d, gen_px(kind, i, img_w[d]), sof_first && (i == 0));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        va = 1'b0; vb = 1'b0; sa = 1'b0; sb = 1'b0;
        qa.delete();
        qb.delete();
        for (int d = 0; d < 2; d++) begin
            last_conv[d] = '0; mr[d] = 0; mc[d] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_valid_a", {31'd0, valid_a}, 0);
        check_eq("rst_conv_a", {24'd0, conv_a}, 0);
        check_eq("rst_eof_a", {31'd0, eof_a}, 0);
        check_eq("rst_valid_b", {31'd0, valid_b}, 0);
        check_eq("rst_conv_b", {30'd0, conv_b}, 0);
    endtask

    task automatic mon(input int d, input logic v, input logic [7:0] co, input logic e);
        exp_t x;
        bit   due;
        due = 1'b0;
        if (d == 0) begin
            if (qa.size() > 0 && qa[0].cyc == cyc) begin x = qa.pop_front(); due = 1'b1; end
        end else begin
            if (qb.size() > 0 && qb[0].cyc == cyc) begin x = qb.pop_front(); due = 1'b1; end
        end
        if (v === 1'b1) dv[d]++;
        if (e === 1'b1) de[d]++;
        if (due) begin
            check_eq($sformatf("valid%0d", d), {31'd0, v}, 1);
            check_eq($sformatf("conv%0d", d), {24'd0, co}, {24'd0, x.conv});
            check_eq($sformatf("eof%0d", d), {31'd0, e}, {31'd0, x.eof});
            last_conv[d] = x.conv;
        end else begin
            check_eq($sformatf("valid_idle%0d", d), {31'd0, v}, 0);
            check_eq($sformatf("conv_hold%0d", d), {24'd0, co}, {24'd0, last_conv[d]});
            check_eq($sformatf("eof_idle%0d", d), {31'd0, e}, 0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            mon(0, valid_a, conv_a, eof_a);
            mon(1, valid_b, {6'd0, conv_b}, eof_b);
        end
    end

    task automatic check_frame(input string tag, input int d, input int v0, input int e0,
                               input int nv, input int ne);
        check_eq({tag, "_outs"}, dv[d] - v0, nv);
        check_eq({tag, "_eofs"}, de[d] - e0, ne);
    endtask

    initial begin
        int v0, e0;
        for (int ch = 0; ch < 8; ch++) begin
            wt[0][ch] = WA[ch*9 +: 9];
            th[0][ch] = TA[ch*4 +: 4];
            wt[1][ch] = (ch < 2) ? WB[ch*9 +: 9] : 9'h0;
            th[1][ch] = (ch < 2) ? TB[ch*4 +: 4] : 4'd0;
        end
        dv = '{0, 0};
        de = '{0, 0};
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;

        // All-zero frame, continuous.
        v0 = dv[0]; e0 = de[0];
        run_frame(0, 0, 784, 1'b1, 1'b0);
        check_frame("zero", 0, v0, e0, 676, 1);

        // Vertical stripes, continuous then with gaps, no sof.
        v0 = dv[0]; e0 = de[0];
        run_frame(0, 1, 784, 1'b0, 1'b0);
        check_frame("stripe", 0, v0, e0, 676, 1);
        v0 = dv[0]; e0 = de[0];
        run_frame(0, 1, 784, 1'b0, 1'b1);
        check_frame("stripe_gap", 0, v0, e0, 676, 1);

        // Frame aborted by sof at pixel 300, then a full frame.
        v0 = dv[0]; e0 = de[0];
        run_frame(0, 2, 300, 1'b0, 1'b0);
        check_eq("abort_eofs", de[0] - e0, 0);
        v0 = dv[0]; e0 = de[0];
        run_frame(0, 2, 784, 1'b1, 1'b0);
        check_frame("after_abort", 0, v0, e0, 676, 1);

        // Reset mid-frame, then a full frame without sof.
        run_frame(0, 2, 400, 1'b0, 1'b0);
        do_reset();
        v0 = dv[0]; e0 = de[0];
        run_frame(0, 2, 784, 1'b0, 1'b1);
        check_frame("after_rst", 0, v0, e0, 676, 1);

        // Small instance: exact-match frame, then random frames.
        v0 = dv[1]; e0 = de[1];
        run_frame(1, 3, 20, 1'b1, 1'b0);
        check_frame("small_ones", 1, v0, e0, 6, 1);
        v0 = dv[1]; e0 = de[1];
        run_frame(1, 2, 60, 1'b0, 1'b1);
        check_frame("small_rand", 1, v0, e0, 18, 3);

        check_eq("qa_drained", qa.size(), 0);
        check_eq("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
